// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
package reg_file_pkg;

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  // Condition code from the word's sign bit and an all-zero flag; the caller
  // supplies both so this works for any word width.
  function automatic logic [2:0] nzp_of(input logic msb, input logic is_zero);
    logic [2:0] code;
    code = NZP_P;
    if (msb) begin
      code = NZP_N;
    end else if (is_zero) begin
      code = NZP_Z;
    end
    return code;
  endfunction

endpackage

// File: rtl/reg_n.sv
// Single WIDTH-bit register with async reset, sync clear and load enable.
module reg_n #(
  parameter int unsigned     WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset beats clear, clear beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (clear) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_n.sv
// DEPTH x WIDTH register file: two combinational read ports with write-through
// bypass, one synchronous write port, and a registered NZP condition code.
module reg_file_n
  import reg_file_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             ld_reg,
  input  logic [AW-1:0]    dr,
  input  logic [WIDTH-1:0] din,
  input  logic             ld_cc,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  output logic [WIDTH-1:0] sr1_out,
  output logic [WIDTH-1:0] sr2_out,
  output logic [2:0]       nzp
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [2:0]       nzp_next;

  // Storage array; each word loads only when it is the decoded destination.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_n #(
      .WIDTH     (WIDTH),
      .RESET_VAL ('0)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .load  (ld_reg && (dr == AW'(i))),
      .d     (din),
      .q     (regs[i])
    );
  end

  assign nzp_next = nzp_of(din[WIDTH-1], din == '0);

  // Condition-code register, resets to Z so exactly one bit is always set.
  reg_n #(
    .WIDTH     (3),
    .RESET_VAL (NZP_Z)
  ) u_nzp (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .load  (ld_cc),
    .d     (nzp_next),
    .q     (nzp)
  );

  // Read muxes with same-cycle forwarding of the pending write.
  always_comb begin
    sr1_out = regs[sr1];
    sr2_out = regs[sr2];
    if (ld_reg && (dr == sr1)) begin
      sr1_out = din;
    end
    if (ld_reg && (dr == sr2)) begin
      sr2_out = din;
    end
  end

endmodule

// File: tb/tb_reg_file_n.sv
// Self-checking bench for reg_file_n: default 16x8 instance plus an 8x4 instance.
`timescale 1ns/100ps
module tb_reg_file_n;

  logic        clk = 1'b0;
  logic        reset, clear, ld_reg, ld_cc;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] din, sr1_out, sr2_out;
  logic [2:0]  nzp;

  logic        b_clear, b_ld_reg, b_ld_cc;
  logic [1:0]  b_dr, b_sr1, b_sr2;
  logic [7:0]  b_din, b_sr1_out, b_sr2_out;
  logic [2:0]  b_nzp;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [15:0] mem_a [8];
  logic [2:0]  cc_a;
  logic [7:0]  mem_b [4];
  logic [2:0]  cc_b;

  reg_file_n dut_a (
    .clk(clk), .reset(reset), .clear(clear), .ld_reg(ld_reg), .dr(dr), .din(din),
    .ld_cc(ld_cc), .sr1(sr1), .sr2(sr2), .sr1_out(sr1_out), .sr2_out(sr2_out), .nzp(nzp)
  );

  reg_file_n #(.WIDTH(8), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear), .ld_reg(b_ld_reg), .dr(b_dr), .din(b_din),
    .ld_cc(b_ld_cc), .sr1(b_sr1), .sr2(b_sr2), .sr1_out(b_sr1_out), .sr2_out(b_sr2_out),
    .nzp(b_nzp)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition code derived from the signed value of the word.
  function automatic logic [2:0] cc16(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] cc8(input logic [7:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 8'd0)      return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] rd_a(input logic [2:0] a);
    return (ld_reg && dr == a) ? din : mem_a[a];
  endfunction

  function automatic logic [7:0] rd_b(input logic [1:0] a);
    return (b_ld_reg && b_dr == a) ? b_din : mem_b[a];
  endfunction

  // Model update: reset wipes everything, clear wins over writes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem_a[i] = '0;
      for (int i = 0; i < 4; i++) mem_b[i] = '0;
      cc_a = 3'b010;
      cc_b = 3'b010;
    end else begin
      if (clear) begin
        for (int i = 0; i < 8; i++) mem_a[i] = '0;
        cc_a = 3'b010;
      end else begin
        if (ld_reg) mem_a[dr] = din;
        if (ld_cc)  cc_a = cc16(din);
      end
      if (b_clear) begin
        for (int i = 0; i < 4; i++) mem_b[i] = '0;
        cc_b = 3'b010;
      end else begin
        if (b_ld_reg) mem_b[b_dr] = b_din;
        if (b_ld_cc)  cc_b = cc8(b_din);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("a_sr1", sr1_out, rd_a(sr1));
      chk("a_sr2", sr2_out, rd_a(sr2));
      chk("a_nzp", 16'(nzp), 16'(cc_a));
      chk("b_sr1", 16'(b_sr1_out), 16'(rd_b(b_sr1)));
      chk("b_sr2", 16'(b_sr2_out), 16'(rd_b(b_sr2)));
      chk("b_nzp", 16'(b_nzp), 16'(cc_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0;
    dr = '0; sr1 = '0; sr2 = '0; din = '0;
    b_clear = 1'b0; b_ld_reg = 1'b0; b_ld_cc = 1'b0;
    b_dr = '0; b_sr1 = '0; b_sr2 = '0; b_din = '0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("lit_reset_sr1", sr1_out, 16'h0000);
    chk("lit_reset_nzp", 16'(nzp), 16'h0002);
    tick();
    reset = 1'b0;

    // Write then read back
    ld_reg = 1'b1; dr = 3'd3; din = 16'h1234;
    tick();
    dr = 3'd5; din = 16'hBEEF;
    tick();
    ld_reg = 1'b0; sr1 = 3'd3; sr2 = 3'd5;
    @(negedge clk);
    chk("lit_rd3", sr1_out, 16'h1234);
    chk("lit_rd5", sr2_out, 16'hBEEF);
    tick();
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      @(negedge clk);
      chk("lit_sweep", sr1_out, (i == 3) ? 16'h1234 : (i == 5) ? 16'hBEEF : 16'h0000);
      tick();
    end

    // Bypass on both ports
    ld_reg = 1'b1; dr = 3'd2; din = 16'h0001;
    tick();
    din = 16'hA5A5; sr1 = 3'd2; sr2 = 3'd2;
    @(negedge clk);
    chk("lit_byp1", sr1_out, 16'hA5A5);
    chk("lit_byp2", sr2_out, 16'hA5A5);
    tick();
    ld_reg = 1'b0;
    @(negedge clk);
    chk("lit_after_byp", sr1_out, 16'hA5A5);
    tick();

    // Condition codes
    ld_cc = 1'b1; din = 16'h8000;
    tick();
    din = 16'h0000;
    @(negedge clk);
    chk("lit_nzp_n", 16'(nzp), 16'h0004);
    tick();
    din = 16'h7FFF;
    @(negedge clk);
    chk("lit_nzp_z", 16'(nzp), 16'h0002);
    tick();
    ld_cc = 1'b0; ld_reg = 1'b1; dr = 3'd1; din = 16'h8000;
    @(negedge clk);
    chk("lit_nzp_p", 16'(nzp), 16'h0001);
    tick();
    ld_reg = 1'b0; sr1 = 3'd1;
    @(negedge clk);
    chk("lit_nzp_hold", 16'(nzp), 16'h0001);
    chk("lit_rd1", sr1_out, 16'h8000);
    tick();

    // ld_cc alone
    ld_cc = 1'b1; din = 16'h0000;
    tick();
    ld_cc = 1'b0; din = 16'h4321;
    @(negedge clk);
    chk("lit_cc_alone", 16'(nzp), 16'h0002);
    tick();

    // Back-to-back writes to one address
    ld_reg = 1'b1; dr = 3'd4; din = 16'h1111;
    tick();
    din = 16'h2222;
    tick();
    ld_reg = 1'b0; sr1 = 3'd4; sr2 = 3'd3;
    @(negedge clk);
    chk("lit_b2b", sr1_out, 16'h2222);
    chk("lit_rd3_again", sr2_out, 16'h1234);
    tick();

    // Clear beats write and ld_cc
    clear = 1'b1; ld_reg = 1'b1; dr = 3'd7; din = 16'hFFFF; ld_cc = 1'b1; sr1 = 3'd7; sr2 = 3'd4;
    tick();
    clear = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0;
    @(negedge clk);
    chk("lit_clr_r7", sr1_out, 16'h0000);
    chk("lit_clr_r4", sr2_out, 16'h0000);
    chk("lit_clr_nzp", 16'(nzp), 16'h0002);
    tick();

    // Narrow instance
    b_ld_reg = 1'b1; b_dr = 2'd3; b_din = 8'h80; b_ld_cc = 1'b1;
    tick();
    b_ld_reg = 1'b0; b_ld_cc = 1'b0; b_sr1 = 2'd3; b_sr2 = 2'd0;
    @(negedge clk);
    chk("lit_b_rd3", 16'(b_sr1_out), 16'h0080);
    chk("lit_b_rd0", 16'(b_sr2_out), 16'h0000);
    chk("lit_b_nzp", 16'(b_nzp), 16'h0004);
    tick();
    b_ld_reg = 1'b1; b_dr = 2'd0; b_din = 8'h7F;
    @(negedge clk);
    chk("lit_b_byp", 16'(b_sr2_out), 16'h007F);
    tick();
    b_ld_reg = 1'b0;

    // Mid-cycle asynchronous reset
    ld_reg = 1'b1; dr = 3'd6; din = 16'h5A5A; ld_cc = 1'b1;
    tick();
    ld_reg = 1'b0; ld_cc = 1'b0; sr1 = 3'd6;
    @(negedge clk);
    chk("lit_rd6", sr1_out, 16'h5A5A);
    chk("lit_nzp_p2", 16'(nzp), 16'h0001);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(i);
      #0.2;
      chk("lit_async_sr1", sr1_out, 16'h0000);
      chk("lit_async_sr2", sr2_out, 16'h0000);
    end
    chk("lit_async_nzp", 16'(nzp), 16'h0002);
    chk("lit_async_b", 16'(b_sr2_out), 16'h0000);
    #0.5 reset = 1'b0;
    tick();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
